// File: rtl/scr1_pipe_lsu_mo_pkg.sv
// Shared types for the multi-outstanding LSU: EXU command, exception cause, DMEM interface enums.
package scr1_pipe_lsu_mo_pkg;

  typedef enum logic [3:0] {
    SCR1_LSU_CMD_NONE = 4'd0,
    SCR1_LSU_CMD_LB   = 4'd1,
    SCR1_LSU_CMD_LH   = 4'd2,
    SCR1_LSU_CMD_LW   = 4'd3,
    SCR1_LSU_CMD_LBU  = 4'd4,
    SCR1_LSU_CMD_LHU  = 4'd5,
    SCR1_LSU_CMD_SB   = 4'd6,
    SCR1_LSU_CMD_SH   = 4'd7,
    SCR1_LSU_CMD_SW   = 4'd8
  } type_scr1_lsu_cmd_sel_e;

  typedef enum logic [3:0] {
    SCR1_EXC_CODE_INSTR_MISALIGN    = 4'd0,
    SCR1_EXC_CODE_INSTR_ACCESS_FAULT = 4'd1,
    SCR1_EXC_CODE_ILLEGAL_INSTR     = 4'd2,
    SCR1_EXC_CODE_BREAKPOINT        = 4'd3,
    SCR1_EXC_CODE_LD_ADDR_MISALIGN  = 4'd4,
    SCR1_EXC_CODE_LD_ACCESS_FAULT   = 4'd5,
    SCR1_EXC_CODE_ST_ADDR_MISALIGN  = 4'd6,
    SCR1_EXC_CODE_ST_ACCESS_FAULT   = 4'd7
  } type_scr1_exc_code_e;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Occupancy counter width; depth never exceeds 4
  localparam int unsigned PEND_CNT_W = 3;

  // Number of address bits selecting a byte lane inside one DMEM beat
  function automatic int unsigned lane_off_w(input int unsigned dwidth);
    return $clog2(dwidth / 8);
  endfunction

endpackage

// File: rtl/scr1_lsu_pend_fifo.sv
// In-order queue of issued DMEM transactions: command, lane offset and a per-entry discard mark.
module scr1_lsu_pend_fifo
  import scr1_pipe_lsu_mo_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OFFW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  type_scr1_lsu_cmd_sel_e push_cmd,
  input  logic [OFFW-1:0]        push_off,
  input  logic                   pop,
  input  logic                   discard_all,
  output type_scr1_lsu_cmd_sel_e head_cmd,
  output logic [OFFW-1:0]        head_off,
  output logic                   head_discard,
  output logic [PEND_CNT_W-1:0]  count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  type_scr1_lsu_cmd_sel_e cmd_q [DEPTH];
  logic [OFFW-1:0]        off_q [DEPTH];
  logic [DEPTH-1:0]       disc_q;
  logic [PTRW-1:0]        wptr;
  logic [PTRW-1:0]        rptr;
  logic                   push_ok;
  logic                   pop_ok;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign full     = (count == PEND_CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  assign head_cmd     = cmd_q[rptr];
  assign head_off     = off_q[rptr];
  assign head_discard = disc_q[rptr];

  always_ff @(posedge clk, negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= ptr_inc(wptr);
      if (pop_ok)  rptr <= ptr_inc(rptr);
      if (push_ok && !pop_ok)      count <= count + PEND_CNT_W'(1);
      else if (!push_ok && pop_ok) count <= count - PEND_CNT_W'(1);
    end
  end

  // A flush also marks the slot written in the same cycle
  always_ff @(posedge clk, negedge rst_n) begin
    if (!rst_n) begin
      disc_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push_ok && (wptr == PTRW'(i))) disc_q[i] <= discard_all;
        else if (discard_all)              disc_q[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      cmd_q[wptr] <= push_cmd;
      off_q[wptr] <= push_off;
    end
  end

endmodule

// File: rtl/scr1_pipe_lsu_mo.sv
// Load/store unit with up to OUTST_DEPTH in-order DMEM transactions, lane steering and flush.
module scr1_pipe_lsu_mo
  import scr1_pipe_lsu_mo_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DMEM_AWIDTH = 32,
  parameter int unsigned DMEM_DWIDTH = 32,
  parameter int unsigned OUTST_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exu2lsu_req,
  input  type_scr1_lsu_cmd_sel_e   exu2lsu_cmd,
  input  logic [XLEN-1:0]          exu2lsu_addr,
  input  logic [XLEN-1:0]          exu2lsu_s_data,
  input  logic                     exu2lsu_flush,
  output logic                     lsu2exu_req_ack,
  output logic                     lsu2exu_rdy,
  output logic [XLEN-1:0]          lsu2exu_l_data,
  output logic                     lsu2exu_exc,
  output type_scr1_exc_code_e      lsu2exu_exc_code,
  output logic                     lsu2dmem_req,
  output type_scr1_mem_cmd_e       lsu2dmem_cmd,
  output type_scr1_mem_width_e     lsu2dmem_width,
  output logic [DMEM_AWIDTH-1:0]   lsu2dmem_addr,
  output logic [DMEM_DWIDTH-1:0]   lsu2dmem_wdata,
  output logic [DMEM_DWIDTH/8-1:0] lsu2dmem_be,
  input  logic                     dmem2lsu_req_ack,
  input  logic [DMEM_DWIDTH-1:0]   dmem2lsu_rdata,
  input  type_scr1_mem_resp_e      dmem2lsu_resp
);

  localparam int unsigned OFFW  = lane_off_w(DMEM_DWIDTH);
  localparam int unsigned BEW   = DMEM_DWIDTH / 8;
  localparam int unsigned NWORD = DMEM_DWIDTH / 32;

  type_scr1_mem_width_e   req_size;
  logic                   req_store;
  logic                   cmd_vld;
  logic                   misalign;
  logic [3:0]             size_mask;
  logic [31:0]            store_word;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   resp_valid;
  logic                   mis_exc;
  logic                   full;
  logic                   empty;
  logic [PEND_CNT_W-1:0]  pend_count;
  type_scr1_lsu_cmd_sel_e head_cmd;
  logic [OFFW-1:0]        head_off;
  logic                   head_discard;
  logic                   head_store;
  logic [DMEM_DWIDTH-1:0] rd_shift;
  logic [31:0]            ld_word;
  logic [31:0]            ld_ext;

  // Request decode: access size, direction, alignment, store lane replication
  always_comb begin
    req_size   = SCR1_MEM_WIDTH_WORD;
    req_store  = 1'b0;
    store_word = exu2lsu_s_data[31:0];
    case (exu2lsu_cmd)
      SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU: req_size = SCR1_MEM_WIDTH_BYTE;
      SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU: req_size = SCR1_MEM_WIDTH_HWORD;
      SCR1_LSU_CMD_SB: begin
        req_size   = SCR1_MEM_WIDTH_BYTE;
        req_store  = 1'b1;
        store_word = {4{exu2lsu_s_data[7:0]}};
      end
      SCR1_LSU_CMD_SH: begin
        req_size   = SCR1_MEM_WIDTH_HWORD;
        req_store  = 1'b1;
        store_word = {2{exu2lsu_s_data[15:0]}};
      end
      SCR1_LSU_CMD_SW: req_store = 1'b1;
      default: ;
    endcase
    case (req_size)
      SCR1_MEM_WIDTH_BYTE:  size_mask = 4'h1;
      SCR1_MEM_WIDTH_HWORD: size_mask = 4'h3;
      default:              size_mask = 4'hF;
    endcase
  end

  assign cmd_vld    = (exu2lsu_cmd != SCR1_LSU_CMD_NONE);
  assign misalign   = cmd_vld & (((req_size == SCR1_MEM_WIDTH_HWORD) & exu2lsu_addr[0])
                               | ((req_size == SCR1_MEM_WIDTH_WORD) & (|exu2lsu_addr[1:0])));
  assign issue      = exu2lsu_req & cmd_vld & ~misalign & ~full & ~exu2lsu_flush;
  assign push       = issue & dmem2lsu_req_ack;
  assign resp_valid = (dmem2lsu_resp == SCR1_MEM_RESP_RDY_OK) | (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER);
  assign pop        = resp_valid & ~empty;
  // Misaligned requests wait for the queue to drain so exceptions stay in program order
  assign mis_exc    = exu2lsu_req & misalign & empty;
  assign head_store = head_cmd inside {SCR1_LSU_CMD_SB, SCR1_LSU_CMD_SH, SCR1_LSU_CMD_SW};

  scr1_lsu_pend_fifo #(
    .DEPTH (OUTST_DEPTH),
    .OFFW  (OFFW)
  ) u_pend (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_cmd     (exu2lsu_cmd),
    .push_off     (exu2lsu_addr[OFFW-1:0]),
    .pop          (pop),
    .discard_all  (exu2lsu_flush),
    .head_cmd     (head_cmd),
    .head_off     (head_off),
    .head_discard (head_discard),
    .count        (pend_count),
    .full         (full),
    .empty        (empty)
  );

  // Load data: align the head lane to bit 0, then extend
  always_comb begin
    rd_shift = dmem2lsu_rdata >> {head_off, 3'b000};
    ld_word  = rd_shift[31:0];
    case (head_cmd)
      SCR1_LSU_CMD_LB:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      SCR1_LSU_CMD_LBU: ld_ext = {24'h0, ld_word[7:0]};
      SCR1_LSU_CMD_LH:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      SCR1_LSU_CMD_LHU: ld_ext = {16'h0, ld_word[15:0]};
      SCR1_LSU_CMD_LW:  ld_ext = ld_word;
      default:          ld_ext = '0;
    endcase
  end

  // Outputs are held at zero while reset is asserted
  always_comb begin
    lsu2dmem_req     = 1'b0;
    lsu2dmem_cmd     = SCR1_MEM_CMD_RD;
    lsu2dmem_width   = SCR1_MEM_WIDTH_BYTE;
    lsu2dmem_addr    = '0;
    lsu2dmem_wdata   = '0;
    lsu2dmem_be      = '0;
    lsu2exu_req_ack  = 1'b0;
    lsu2exu_rdy      = 1'b0;
    lsu2exu_l_data   = '0;
    lsu2exu_exc      = 1'b0;
    lsu2exu_exc_code = SCR1_EXC_CODE_INSTR_MISALIGN;
    if (rst_n) begin
      lsu2dmem_req    = issue;
      lsu2dmem_cmd    = req_store ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      lsu2dmem_width  = req_size;
      lsu2dmem_addr   = DMEM_AWIDTH'(exu2lsu_addr);
      lsu2dmem_wdata  = {NWORD{store_word}};
      lsu2dmem_be     = BEW'(size_mask) << exu2lsu_addr[OFFW-1:0];
      lsu2exu_req_ack = push;
      if (pop && !head_discard) begin
        lsu2exu_rdy    = 1'b1;
        lsu2exu_l_data = XLEN'(ld_ext);
        if (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER) begin
          lsu2exu_exc      = 1'b1;
          lsu2exu_exc_code = head_store ? SCR1_EXC_CODE_ST_ACCESS_FAULT : SCR1_EXC_CODE_LD_ACCESS_FAULT;
        end
      end else if (mis_exc) begin
        lsu2exu_exc      = 1'b1;
        lsu2exu_exc_code = req_store ? SCR1_EXC_CODE_ST_ADDR_MISALIGN : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
      end
    end
  end

  stray_resp_cov: cover property (@(posedge clk) disable iff (!rst_n)
    resp_valid && (pend_count == '0));

endmodule

// File: tb/tb_scr1_pipe_lsu_mo.sv
// Directed bench: 64-bit/depth-2 LSU for most scenarios, 32-bit/depth-4 LSU for mid-flight reset.
module tb_scr1_pipe_lsu_mo;
  import scr1_pipe_lsu_mo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  type_scr1_lsu_cmd_sel_e cmd;
  logic [31:0] addr, sdata;
  logic        flush, dack;

  logic a_req, a_ack, a_rdy, a_exc, a_dreq;
  logic [31:0] a_ldata, a_daddr;
  type_scr1_exc_code_e  a_code;
  type_scr1_mem_cmd_e   a_dcmd;
  type_scr1_mem_width_e a_dwidth;
  logic [63:0] a_wdata, a_rdata;
  logic [7:0]  a_be;
  type_scr1_mem_resp_e  a_resp;

  logic b_req, b_ack, b_rdy, b_exc, b_dreq;
  logic [31:0] b_ldata, b_daddr;
  type_scr1_exc_code_e  b_code;
  type_scr1_mem_cmd_e   b_dcmd;
  type_scr1_mem_width_e b_dwidth;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  type_scr1_mem_resp_e  b_resp;

  int n_chk = 0;
  int n_fail = 0;

  scr1_pipe_lsu_mo #(.XLEN(32), .DMEM_AWIDTH(32), .DMEM_DWIDTH(64), .OUTST_DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .exu2lsu_req(a_req), .exu2lsu_cmd(cmd), .exu2lsu_addr(addr), .exu2lsu_s_data(sdata),
    .exu2lsu_flush(flush),
    .lsu2exu_req_ack(a_ack), .lsu2exu_rdy(a_rdy), .lsu2exu_l_data(a_ldata),
    .lsu2exu_exc(a_exc), .lsu2exu_exc_code(a_code),
    .lsu2dmem_req(a_dreq), .lsu2dmem_cmd(a_dcmd), .lsu2dmem_width(a_dwidth),
    .lsu2dmem_addr(a_daddr), .lsu2dmem_wdata(a_wdata), .lsu2dmem_be(a_be),
    .dmem2lsu_req_ack(dack), .dmem2lsu_rdata(a_rdata), .dmem2lsu_resp(a_resp)
  );

  scr1_pipe_lsu_mo #(.XLEN(32), .DMEM_AWIDTH(32), .DMEM_DWIDTH(32), .OUTST_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .exu2lsu_req(b_req), .exu2lsu_cmd(cmd), .exu2lsu_addr(addr), .exu2lsu_s_data(sdata),
    .exu2lsu_flush(flush),
    .lsu2exu_req_ack(b_ack), .lsu2exu_rdy(b_rdy), .lsu2exu_l_data(b_ldata),
    .lsu2exu_exc(b_exc), .lsu2exu_exc_code(b_code),
    .lsu2dmem_req(b_dreq), .lsu2dmem_cmd(b_dcmd), .lsu2dmem_width(b_dwidth),
    .lsu2dmem_addr(b_daddr), .lsu2dmem_wdata(b_wdata), .lsu2dmem_be(b_be),
    .dmem2lsu_req_ack(dack), .dmem2lsu_rdata(b_rdata), .dmem2lsu_resp(b_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0; cmd = SCR1_LSU_CMD_NONE; addr = '0; sdata = '0;
    flush = 1'b0; dack = 1'b1;
    a_resp = SCR1_MEM_RESP_NOTRDY; a_rdata = '0;
    b_resp = SCR1_MEM_RESP_NOTRDY; b_rdata = '0;
  endtask

  // Two back-to-back loads to one address, then two OK responses carrying the same beat
  task automatic load_pair(input string tag, input type_scr1_lsu_cmd_sel_e c0,
                           input type_scr1_lsu_cmd_sel_e c1, input logic [31:0] ad,
                           input logic [63:0] rd, input logic [31:0] e0, input logic [31:0] e1);
    a_req = 1'b1; cmd = c0; addr = ad;
    smp(); check({tag, "_ack0"}, 64'(a_ack), 64'd1); nxt();
    cmd = c1;
    smp(); check({tag, "_ack1"}, 64'(a_ack), 64'd1); nxt();
    a_req = 1'b0; a_resp = SCR1_MEM_RESP_RDY_OK; a_rdata = rd;
    smp(); check({tag, "_d0"}, 64'(a_ldata), 64'(e0)); nxt();
    smp(); check({tag, "_d1"}, 64'(a_ldata), 64'(e1)); nxt();
    a_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    a_req = 1'b1; cmd = SCR1_LSU_CMD_LW; addr = 32'h100; a_resp = SCR1_MEM_RESP_RDY_OK;
    smp();
    check("rst_dreq", 64'(a_dreq), 64'd0);
    check("rst_ack", 64'(a_ack), 64'd0);
    check("rst_rdy", 64'(a_rdy), 64'd0);
    check("rst_code", 64'(a_code), 64'(SCR1_EXC_CODE_INSTR_MISALIGN));
    check("rst_addr", 64'(a_daddr), 64'd0);
    nxt();
    rst_n = 1'b1; idle();
    nxt();

    // LW pipelining; third request sees a full queue
    a_req = 1'b1; cmd = SCR1_LSU_CMD_LW; addr = 32'h100;
    smp(); check("lw0_dreq", 64'(a_dreq), 64'd1); check("lw0_ack", 64'(a_ack), 64'd1);
    check("lw0_be", 64'(a_be), 64'h0F); check("lw0_width", 64'(a_dwidth), 64'(SCR1_MEM_WIDTH_WORD));
    nxt();
    addr = 32'h104;
    smp(); check("lw1_ack", 64'(a_ack), 64'd1); check("lw1_be", 64'(a_be), 64'hF0); nxt();
    addr = 32'h108;
    smp(); check("lw2_ack", 64'(a_ack), 64'd0); check("lw2_dreq", 64'(a_dreq), 64'd0); nxt();
    a_req = 1'b0; a_resp = SCR1_MEM_RESP_RDY_OK; a_rdata = 64'h0000_0000_0000_000A;
    smp(); check("lw_rdy0", 64'(a_rdy), 64'd1); check("lw_d0", 64'(a_ldata), 64'hA); nxt();
    a_rdata = 64'h0000_000B_0000_0000;
    smp(); check("lw_rdy1", 64'(a_rdy), 64'd1); check("lw_d1", 64'(a_ldata), 64'hB); nxt();
    a_resp = SCR1_MEM_RESP_NOTRDY;
    smp(); check("lw_idle_rdy", 64'(a_rdy), 64'd0); check("lw_cnt", 64'(u_a.pend_count), 64'd0); nxt();

    // Misaligned LH waits for the outstanding LW
    a_req = 1'b1; cmd = SCR1_LSU_CMD_LW; addr = 32'h200;
    smp(); check("mis_lw_ack", 64'(a_ack), 64'd1); nxt();
    cmd = SCR1_LSU_CMD_LH; addr = 32'h101;
    smp(); check("mis_dreq", 64'(a_dreq), 64'd0); check("mis_exc_wait", 64'(a_exc), 64'd0); nxt();
    a_resp = SCR1_MEM_RESP_RDY_OK; a_rdata = 64'h0000_0000_DEAD_BEEF;
    smp(); check("mis_lw_rdy", 64'(a_rdy), 64'd1); check("mis_lw_d", 64'(a_ldata), 64'hDEADBEEF);
    check("mis_exc_resp", 64'(a_exc), 64'd0); nxt();
    a_resp = SCR1_MEM_RESP_NOTRDY;
    smp(); check("mis_exc", 64'(a_exc), 64'd1); check("mis_code", 64'(a_code), 64'd4);
    check("mis_rdy", 64'(a_rdy), 64'd0); check("mis_dreq2", 64'(a_dreq), 64'd0); nxt();
    cmd = SCR1_LSU_CMD_SW; addr = 32'h102;
    smp(); check("smis_exc", 64'(a_exc), 64'd1); check("smis_code", 64'(a_code), 64'd6); nxt();
    idle();

    // Lane steering and extension on the 64-bit port
    load_pair("lb", SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU, 32'h1005, 64'h0000_80FF_0000_0000,
              32'hFFFF_FF80, 32'h0000_0080);
    load_pair("lh", SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, 32'h1004, 64'h0000_80FF_0000_0000,
              32'hFFFF_80FF, 32'h0000_80FF);
    dack = 1'b0; a_req = 1'b1;
    cmd = SCR1_LSU_CMD_SH; addr = 32'h6; sdata = 32'hABCD_1234;
    smp(); check("sh_be", 64'(a_be), 64'hC0); check("sh_wdata", a_wdata, 64'h1234_1234_1234_1234);
    check("sh_cmd", 64'(a_dcmd), 64'(SCR1_MEM_CMD_WR)); check("sh_ack_noack", 64'(a_ack), 64'd0); nxt();
    cmd = SCR1_LSU_CMD_SB; addr = 32'h3; sdata = 32'h0000_005A;
    smp(); check("sb_be", 64'(a_be), 64'h08); check("sb_wdata", a_wdata, 64'h5A5A_5A5A_5A5A_5A5A); nxt();
    cmd = SCR1_LSU_CMD_SW; addr = 32'h4; sdata = 32'hCAFE_F00D;
    smp(); check("sw_be", 64'(a_be), 64'hF0); check("sw_wdata", a_wdata, 64'hCAFE_F00D_CAFE_F00D); nxt();
    idle();

    // Access faults
    a_req = 1'b1; cmd = SCR1_LSU_CMD_SW; addr = 32'h10;
    smp(); check("swf_ack", 64'(a_ack), 64'd1); nxt();
    a_req = 1'b0; a_resp = SCR1_MEM_RESP_RDY_ER;
    smp(); check("swf_rdy", 64'(a_rdy), 64'd1); check("swf_exc", 64'(a_exc), 64'd1);
    check("swf_code", 64'(a_code), 64'd7); nxt();
    a_resp = SCR1_MEM_RESP_NOTRDY;
    smp(); check("swf_cnt", 64'(u_a.pend_count), 64'd0); nxt();
    a_req = 1'b1; cmd = SCR1_LSU_CMD_LW; addr = 32'h20;
    smp(); check("lwf_ack", 64'(a_ack), 64'd1); nxt();
    a_req = 1'b0; a_resp = SCR1_MEM_RESP_RDY_ER;
    smp(); check("lwf_exc", 64'(a_exc), 64'd1); check("lwf_code", 64'(a_code), 64'd5); nxt();
    idle();

    // Flush with two loads in flight
    a_req = 1'b1; cmd = SCR1_LSU_CMD_LW; addr = 32'h300;
    smp(); check("fl_ack0", 64'(a_ack), 64'd1); nxt();
    addr = 32'h304;
    smp(); check("fl_ack1", 64'(a_ack), 64'd1); nxt();
    flush = 1'b1; addr = 32'h308;
    smp(); check("fl_dreq", 64'(a_dreq), 64'd0); nxt();
    flush = 1'b0; a_req = 1'b0; a_resp = SCR1_MEM_RESP_RDY_OK; a_rdata = 64'h55;
    smp(); check("fl_rdy0", 64'(a_rdy), 64'd0); nxt();
    a_resp = SCR1_MEM_RESP_RDY_ER;
    smp(); check("fl_rdy1", 64'(a_rdy), 64'd0); check("fl_exc1", 64'(a_exc), 64'd0); nxt();
    a_resp = SCR1_MEM_RESP_NOTRDY; a_req = 1'b1; addr = 32'h30C;
    smp(); check("fl_new_ack", 64'(a_ack), 64'd1); nxt();
    a_req = 1'b0; a_resp = SCR1_MEM_RESP_RDY_OK; a_rdata = 64'h0000_0077_0000_0000;
    smp(); check("fl_new_rdy", 64'(a_rdy), 64'd1); check("fl_new_d", 64'(a_ldata), 64'h77); nxt();
    idle();

    // Mid-flight reset on the depth-4 instance
    b_req = 1'b1; cmd = SCR1_LSU_CMD_LW;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h400 + 32'(4 * i);
      smp(); check("mr_ack", 64'(b_ack), 64'd1); nxt();
    end
    addr = 32'h40C;
    smp(); check("mr_cnt3", 64'(u_b.pend_count), 64'd3); nxt();
    rst_n = 1'b0; b_resp = SCR1_MEM_RESP_RDY_OK; b_rdata = 32'hFFFF_FFFF; sdata = 32'h1234_5678;
    smp();
    check("mr_dreq", 64'(b_dreq), 64'd0); check("mr_ack_rst", 64'(b_ack), 64'd0);
    check("mr_rdy", 64'(b_rdy), 64'd0); check("mr_ldata", 64'(b_ldata), 64'd0);
    check("mr_exc", 64'(b_exc), 64'd0); check("mr_code", 64'(b_code), 64'd0);
    check("mr_be", 64'(b_be), 64'd0); check("mr_wdata", 64'(b_wdata), 64'd0);
    check("mr_addr", 64'(b_daddr), 64'd0); check("mr_dcmd", 64'(b_dcmd), 64'd0);
    check("mr_dwidth", 64'(b_dwidth), 64'd0); check("mr_cnt0", 64'(u_b.pend_count), 64'd0);
    nxt();
    rst_n = 1'b1; b_req = 1'b0;
    smp(); check("stray_rdy", 64'(b_rdy), 64'd0); check("stray_exc", 64'(b_exc), 64'd0); nxt();
    b_resp = SCR1_MEM_RESP_NOTRDY;
    smp(); check("stray_cnt", 64'(u_b.pend_count), 64'd0); nxt();
    b_req = 1'b1; addr = 32'h500;
    smp(); check("mr_new_ack", 64'(b_ack), 64'd1); nxt();
    b_req = 1'b0; b_resp = SCR1_MEM_RESP_RDY_OK; b_rdata = 32'h1234_5678;
    smp(); check("mr_new_rdy", 64'(b_rdy), 64'd1); check("mr_new_d", 64'(b_ldata), 64'h1234_5678); nxt();
    idle();
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
